// File: rtl/spi_acl_pkg.sv
// rtl/spi_acl_pkg.sv - shared opcodes, register addresses and state encoding for the ACL2 SPI link
package spi_acl_pkg;

   localparam logic [7:0] OP_WRITE     = 8'h0A;
   localparam logic [7:0] OP_READ      = 8'h0B;
   localparam logic [7:0] OP_FIFO      = 8'h0D;

   localparam logic [7:0] ADDR_DEVID   = 8'h00;
   localparam logic [7:0] ADDR_X       = 8'h08;
   localparam logic [7:0] ADDR_Y       = 8'h09;
   localparam logic [7:0] ADDR_Z       = 8'h0A;
   localparam logic [7:0] ADDR_SCRATCH = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_FIFO_DATA,
      ST_IGNORE
   } acl_state_e;

   function automatic logic is_read_state(input acl_state_e s);
      return (s == ST_RD_DATA) || (s == ST_FIFO_DATA);
   endfunction

endpackage

// File: rtl/acl_sample_fifo.sv
// rtl/acl_sample_fifo.sv - byte-wide synchronous sample FIFO with show-ahead read data
module acl_sample_fifo #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [7:0]                    push_data,
   input  logic                          pop,
   output logic [7:0]                    pop_data,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   // A pop in the same cycle frees a slot, so a push at full still lands.
   always_comb begin
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/spi_acl_responder.sv
// rtl/spi_acl_responder.sv - SPI mode-0 ACL2 accelerometer emulator: register map, scratch RAM and sample FIFO
module spi_acl_responder
   import spi_acl_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter int         NUM_RW     = 32,
   parameter logic [7:0] DEVID_VAL  = 8'hAD
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          SCLK,
   input  logic                          CS,
   input  logic                          MOSI,
   output logic                          MISO,
   output logic                          MISO_OE,
   input  logic [7:0]                    X_DATA,
   input  logic [7:0]                    Y_DATA,
   input  logic [7:0]                    Z_DATA,
   input  logic                          FIFO_WR_EN,
   input  logic [7:0]                    FIFO_WR_DATA,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic                          FIFO_OVERFLOW,
   output logic                          BUSY
);

   localparam int SW = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;

   // pipe bit 0 = metastable stage, bit 1 = synchronised, bit 2 = previous synchronised
   logic [2:0]  sclk_pipe_q, sclk_pipe_d;
   logic [2:0]  cs_pipe_q, cs_pipe_d;
   logic [1:0]  mosi_pipe_q, mosi_pipe_d;

   acl_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        is_read_q, is_read_d;
   logic        load_pend_q, load_pend_d;
   logic [7:0]  out_q, out_d;
   logic [7:0]  snap_x_q, snap_x_d;
   logic [7:0]  snap_y_q, snap_y_d;
   logic [7:0]  snap_z_q, snap_z_d;
   logic [7:0]  scratch_q [NUM_RW];
   logic [7:0]  scratch_d [NUM_RW];
   logic        ovf_q, ovf_d;

   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [7:0]  rx_byte;
   logic        byte_done;
   logic [7:0]  scr_off;
   logic        scr_hit;
   logic [SW-1:0] scr_idx;
   logic [7:0]  reg_rdata;
   logic        fifo_pop;
   logic [7:0]  fifo_rdata;
   logic        fifo_full;
   logic        fifo_empty;

   always_comb begin
      sclk_pipe_d = {sclk_pipe_q[1], sclk_pipe_q[0], SCLK};
      cs_pipe_d   = {cs_pipe_q[1], cs_pipe_q[0], CS};
      mosi_pipe_d = {mosi_pipe_q[0], MOSI};
   end

   assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
   assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
   assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
   assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];

   assign scr_off = ptr_q - ADDR_SCRATCH;
   assign scr_hit = (ptr_q >= ADDR_SCRATCH) && (32'(scr_off) < 32'(NUM_RW));
   assign scr_idx = scr_off[SW-1:0];

   always_comb begin
      reg_rdata = 8'h00;
      if (ptr_q == ADDR_DEVID)   reg_rdata = DEVID_VAL;
      else if (ptr_q == ADDR_X)  reg_rdata = snap_x_q;
      else if (ptr_q == ADDR_Y)  reg_rdata = snap_y_q;
      else if (ptr_q == ADDR_Z)  reg_rdata = snap_z_q;
      else if (scr_hit)          reg_rdata = scratch_q[scr_idx];
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      is_read_d   = is_read_q;
      load_pend_d = load_pend_q;
      out_d       = out_q;
      snap_x_d    = snap_x_q;
      snap_y_d    = snap_y_q;
      snap_z_d    = snap_z_q;
      scratch_d   = scratch_q;
      fifo_pop    = 1'b0;
      rx_byte     = {shift_q[6:0], mosi_pipe_q[1]};
      byte_done   = sclk_rise && (bit_cnt_q == 3'd7);

      if (cs_rise) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         load_pend_d = 1'b0;
         out_d       = '0;
      end else begin
         if ((state_q != ST_IDLE) && (state_q != ST_IGNORE) && sclk_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d     = ST_CMD;
                  bit_cnt_d   = '0;
                  load_pend_d = 1'b0;
                  out_d       = '0;
                  snap_x_d    = X_DATA;
                  snap_y_d    = Y_DATA;
                  snap_z_d    = Z_DATA;
               end
            end
            ST_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     OP_WRITE: begin state_d = ST_ADDR; is_read_d = 1'b0; end
                     OP_READ:  begin state_d = ST_ADDR; is_read_d = 1'b1; end
                     OP_FIFO:  begin state_d = ST_FIFO_DATA; load_pend_d = 1'b1; end
                     default:  state_d = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (byte_done) begin
                  ptr_d       = rx_byte;
                  state_d     = is_read_q ? ST_RD_DATA : ST_WR_DATA;
                  load_pend_d = is_read_q;
               end
            end
            ST_WR_DATA: begin
               if (byte_done) begin
                  if (scr_hit) scratch_d[scr_idx] = rx_byte;
                  ptr_d = ptr_q + 8'd1;
               end
            end
            ST_RD_DATA, ST_FIFO_DATA: begin
               if (byte_done) load_pend_d = 1'b1;
               // MISO only moves on SCLK falls so the controller's rising-edge sample stays clean.
               if (sclk_fall) begin
                  if (load_pend_q) begin
                     load_pend_d = 1'b0;
                     if (state_q == ST_RD_DATA) begin
                        out_d = reg_rdata;
                        ptr_d = ptr_q + 8'd1;
                     end else if (!fifo_empty) begin
                        out_d    = fifo_rdata;
                        fifo_pop = 1'b1;
                     end else begin
                        out_d = 8'h00;
                     end
                  end else begin
                     out_d = {out_q[6:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ovf_d = ovf_q | (FIFO_WR_EN && fifo_full && !fifo_pop);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sclk_pipe_q <= '0;
         cs_pipe_q   <= '1;
         mosi_pipe_q <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         is_read_q   <= 1'b0;
         load_pend_q <= 1'b0;
         out_q       <= '0;
         snap_x_q    <= '0;
         snap_y_q    <= '0;
         snap_z_q    <= '0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < NUM_RW; i++) scratch_q[i] <= '0;
      end else begin
         sclk_pipe_q <= sclk_pipe_d;
         cs_pipe_q   <= cs_pipe_d;
         mosi_pipe_q <= mosi_pipe_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         is_read_q   <= is_read_d;
         load_pend_q <= load_pend_d;
         out_q       <= out_d;
         snap_x_q    <= snap_x_d;
         snap_y_q    <= snap_y_d;
         snap_z_q    <= snap_z_d;
         ovf_q       <= ovf_d;
         scratch_q   <= scratch_d;
      end
   end

   acl_sample_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .push      (FIFO_WR_EN),
      .push_data (FIFO_WR_DATA),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .count     (FIFO_COUNT),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign MISO_OE       = is_read_state(state_q) && !cs_pipe_q[1];
   assign MISO          = MISO_OE & out_q[7];
   assign BUSY          = ~cs_pipe_q[1];
   assign FIFO_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_spi_acl_responder.sv
// tb/tb_spi_acl_responder.sv - directed bench for spi_acl_responder with a transaction-level model
module tb_spi_acl_responder;

   localparam int FD = 16;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       SCLK = 1'b0;
   logic       CS = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO, MISO_OE, BUSY, FIFO_OVERFLOW;
   logic       FIFO_WR_EN = 1'b0;
   logic [7:0] X_DATA = 8'h00, Y_DATA = 8'h00, Z_DATA = 8'h00;
   logic [7:0] FIFO_WR_DATA = 8'h00;
   logic [4:0] FIFO_COUNT;

   spi_acl_responder dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .SCLK          (SCLK),
      .CS            (CS),
      .MOSI          (MOSI),
      .MISO          (MISO),
      .MISO_OE       (MISO_OE),
      .X_DATA        (X_DATA),
      .Y_DATA        (Y_DATA),
      .Z_DATA        (Z_DATA),
      .FIFO_WR_EN    (FIFO_WR_EN),
      .FIFO_WR_DATA  (FIFO_WR_DATA),
      .FIFO_COUNT    (FIFO_COUNT),
      .FIFO_OVERFLOW (FIFO_OVERFLOW),
      .BUSY          (BUSY)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;

   // model state: scratch RAM, axis snapshot, FIFO contents, sticky overflow
   logic [7:0] m_scr [32];
   logic [7:0] m_snap [3];
   logic [7:0] m_fifo [$];
   logic       m_ovf = 1'b0;

   logic       cmp_en = 1'b0;
   logic       cnt_en = 1'b0;
   logic       exp_oe = 1'b0;
   logic       exp_bit = 1'b0;
   logic [7:0] tx [24];
   logic [7:0] rx [24];
   logic [7:0] expb [24];
   logic       oeb [24];
   int         x_hit = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(posedge SCLK) begin
      if (cmp_en) begin
         check("miso_oe", 32'(MISO_OE), 32'(exp_oe));
         check("miso", 32'(MISO), 32'(exp_bit));
      end
   end

   always @(negedge CLK) begin
      if (cnt_en) begin
         check("fifo_count", 32'(FIFO_COUNT), 32'(m_fifo.size()));
         check("fifo_overflow", 32'(FIFO_OVERFLOW), 32'(m_ovf));
      end
   end

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a == 8'h00) return 8'hAD;
      if (a >= 8'h08 && a <= 8'h0A) return m_snap[int'(a) - 8];
      if (a >= 8'h20 && a < 8'h40) return m_scr[int'(a) - 32];
      return 8'h00;
   endfunction

   task automatic push(input logic [7:0] d);
      @(negedge CLK);
      FIFO_WR_EN = 1'b1;
      FIFO_WR_DATA = d;
      @(posedge CLK);
      #1;
      FIFO_WR_EN = 1'b0;
      if (m_fifo.size() < FD) m_fifo.push_back(d);
      else m_ovf = 1'b1;
   endtask

   task automatic xact(input int nbytes, input int nbits);
      int op, hdr, by, bi;
      logic [7:0] ptr;
      cnt_en = 1'b0;
      m_snap[0] = X_DATA;
      m_snap[1] = Y_DATA;
      m_snap[2] = Z_DATA;
      ptr = tx[1];
      case (tx[0])
         8'h0B:   begin op = 1; hdr = 2; end
         8'h0A:   begin op = 2; hdr = 2; end
         8'h0D:   begin op = 3; hdr = 1; end
         default: begin op = 0; hdr = 24; end
      endcase
      for (int i = 0; i < 24; i++) begin
         oeb[i] = 1'b0;
         expb[i] = 8'h00;
         rx[i] = 8'h00;
         if (i >= hdr && i < nbytes) begin
            if (op == 1) begin
               oeb[i] = 1'b1;
               expb[i] = m_read(ptr);
               ptr = ptr + 8'd1;
            end else if (op == 3) begin
               oeb[i] = 1'b1;
               if (m_fifo.size() > 0) expb[i] = m_fifo.pop_front();
            end
         end
      end
      // the SCLK fall after the final byte loads one more entry
      if (op == 3 && nbits == 0 && m_fifo.size() > 0) void'(m_fifo.pop_front());

      CS = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      check("busy_high", 32'(BUSY), 32'd1);
      cmp_en = 1'b1;
      for (int b = 0; b < nbytes * 8 + nbits; b++) begin
         by = b / 8;
         bi = 7 - (b % 8);
         MOSI = tx[by][bi];
         exp_oe = oeb[by];
         exp_bit = oeb[by] & expb[by][bi];
         if (b == x_hit) X_DATA = 8'h99;
         #80;
         rx[by][bi] = MISO;
         SCLK = 1'b1;
         #80;
         SCLK = 1'b0;
      end
      #80;
      cmp_en = 1'b0;
      CS = 1'b1;
      if (op == 2) begin
         ptr = tx[1];
         for (int i = 2; i < nbytes; i++) begin
            if (ptr >= 8'h20 && ptr < 8'h40) m_scr[int'(ptr) - 32] = tx[i];
            ptr = ptr + 8'd1;
         end
      end
      repeat (6) @(posedge CLK);
      #1;
      check("busy_low", 32'(BUSY), 32'd0);
      check("oe_low_idle", 32'(MISO_OE), 32'd0);
      cnt_en = 1'b1;
   endtask

   initial begin
      foreach (m_scr[i]) m_scr[i] = 8'h00;
      foreach (m_snap[i]) m_snap[i] = 8'h00;
      #23;
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_oe", 32'(MISO_OE), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_count", 32'(FIFO_COUNT), 32'd0);
      check("rst_ovf", 32'(FIFO_OVERFLOW), 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      cnt_en = 1'b1;

      // DEVID read
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h00;
      xact(3, 0);
      check("devid", 32'(rx[2]), 32'h000000AD);

      // aborted write leaves scratch untouched
      tx = '{default: 8'h00};
      tx[0] = 8'h0A; tx[1] = 8'h21; tx[2] = 8'hFF;
      xact(2, 4);
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h21;
      xact(3, 0);
      check("abort_scratch", 32'(rx[2]), 32'h00000000);

      // axis snapshot holds while X changes mid-burst
      X_DATA = 8'h11; Y_DATA = 8'h22; Z_DATA = 8'h33;
      x_hit = 20;
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h08;
      xact(5, 0);
      x_hit = -1;
      check("snap_x", 32'(rx[2]), 32'h00000011);
      check("snap_y", 32'(rx[3]), 32'h00000022);
      check("snap_z", 32'(rx[4]), 32'h00000033);

      // scratch write then read back, then a burst across the scratch boundary
      tx = '{default: 8'h00};
      tx[0] = 8'h0A; tx[1] = 8'h20; tx[2] = 8'h5A; tx[3] = 8'hC3;
      xact(4, 0);
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h20;
      xact(4, 0);
      check("scratch20", 32'(rx[2]), 32'h0000005A);
      check("scratch21", 32'(rx[3]), 32'h000000C3);
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h1F;
      xact(5, 0);
      check("addr1f", 32'(rx[2]), 32'h00000000);
      check("addr20_burst", 32'(rx[3]), 32'h0000005A);

      // FIFO read past empty
      push(8'h01); push(8'h02); push(8'h03);
      tx = '{default: 8'h00};
      tx[0] = 8'h0D;
      xact(5, 0);
      check("fifo_b0", 32'(rx[1]), 32'h00000001);
      check("fifo_b1", 32'(rx[2]), 32'h00000002);
      check("fifo_b2", 32'(rx[3]), 32'h00000003);
      check("fifo_b3_empty", 32'(rx[4]), 32'h00000000);
      check("fifo_drained", 32'(FIFO_COUNT), 32'd0);
      check("fifo_no_ovf", 32'(FIFO_OVERFLOW), 32'd0);

      // overflow: 17 pushes, last one dropped
      for (int i = 0; i <= FD; i++) push(8'h40 + 8'(i));
      @(negedge CLK);
      check("full_count", 32'(FIFO_COUNT), 32'd16);
      check("ovf_set", 32'(FIFO_OVERFLOW), 32'd1);
      tx = '{default: 8'h00};
      tx[0] = 8'h0D;
      xact(17, 0);
      check("ovf_first", 32'(rx[1]), 32'h00000040);
      check("ovf_last_kept", 32'(rx[16]), 32'h0000004F);
      check("ovf_count_end", 32'(FIFO_COUNT), 32'd0);
      check("ovf_sticky", 32'(FIFO_OVERFLOW), 32'd1);

      // illegal opcode stays silent, next transaction is normal
      tx = '{default: 8'h00};
      tx[0] = 8'h55; tx[1] = 8'h0B;
      xact(4, 0);
      check("ignore_rx", 32'(rx[2]), 32'h00000000);
      tx = '{default: 8'h00};
      tx[0] = 8'h0B; tx[1] = 8'h00;
      xact(3, 0);
      check("devid_after_ignore", 32'(rx[2]), 32'h000000AD);

      cnt_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_acl_responder.md
Name: spi_acl_responder

Overview:
- SPI mode-0 peripheral that models the accelerometer end of the ACL2 link. It is the responder for the team's spi_controller.
- Decodes instruction 0x0A (register write), 0x0B (register read) and 0x0D (FIFO read). Serves a small register map and a sample FIFO.
- Used as the bench and loopback target for the controller, and as an emulated sensor on boards with no ACL2 fitted.

Parameters:
- FIFO_DEPTH, 16, sample FIFO depth in bytes (power of 2).
- NUM_RW, 32, number of writable scratch registers at 0x20..0x20+NUM_RW-1.
- DEVID_VAL, 8'hAD, constant value returned at address 0x00.

Ports:
- CLK  in  1  system clock, at least 8x SCLK.
- RESET_N  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from the controller, asynchronous to CLK.
- CS  in  1  active-low chip select, asynchronous.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- MISO_OE  out  1  high while CS is low and the state is a read-data state.
- X_DATA, Y_DATA, Z_DATA  in  8 each  live axis samples.
- FIFO_WR_EN  in  1  push FIFO_WR_DATA into the sample FIFO.
- FIFO_WR_DATA  in  8  sample byte to push.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- FIFO_OVERFLOW  out  1  sticky; cleared only by reset.
- BUSY  out  1  high while CS is low (synchronised).

Behaviour:
- Input synchronisation: SCLK, CS and MOSI each pass through 2 flops. A rise or fall is detected on the synchronised SCLK. All logic runs on CLK.
- Reset: all outputs are 0, state is IDLE, FIFO is empty, scratch registers are 0x00.
- States:
  - IDLE -> CMD on a synchronised CS fall. On that CS fall, X_DATA, Y_DATA and Z_DATA are snapshotted.
  - CMD: shift 8 bits MSB-first on SCLK rises, then decode:
    - 0x0A -> ADDR, then WR_DATA.
    - 0x0B -> ADDR, then RD_DATA.
    - 0x0D -> FIFO_DATA (no address byte).
    - any other value -> IGNORE.
  - ADDR: shift 8 bits into the address pointer.
  - WR_DATA: after each complete byte, write it to the pointer if the pointer is writable, then increment the pointer.
  - RD_DATA and FIFO_DATA: shift the output register out MSB-first.
  - IGNORE: MISO is 0 and no side effects occur until CS rises.
- From any state, a synchronised CS rise returns to IDLE within 1 CLK. A partial byte is discarded with no write and no pop. A mid-transaction assertion of RESET_N low returns to IDLE immediately.
- MISO timing: MISO changes only on SCLK falls. This keeps the controller's rising-edge sample stable.
  - The first read byte loads on the SCLK fall that follows the last rise of the final header byte: bit 16 for RD_DATA, bit 8 for FIFO_DATA.
  - Each later byte loads on the fall after its predecessor's 8th rise.
  - MISO is 0 whenever MISO_OE is 0.
- Register map for reads:
  - 0x00 = DEVID_VAL.
  - 0x08, 0x09, 0x0A = snapshot of X, Y, Z.
  - 0x20.. = scratch registers.
  - Every other address reads 0x00.
- Register writes: only scratch addresses are writable. Writes elsewhere are silently dropped.
- Address pointer: in RD_DATA it increments at each byte load, in WR_DATA at each byte write. It wraps 0xFF -> 0x00.
- FIFO read:
  - Each byte load pops one entry.
  - If the FIFO is empty, the loaded byte is 0x00 and nothing is popped.
  - Burst reads continue until CS rises.
- FIFO push:
  - When FIFO_WR_EN is high and the FIFO is not full, the byte is pushed.
  - When full, the byte is dropped and FIFO_OVERFLOW is set.
  - A push and a pop in the same CLK are both honoured and FIFO_COUNT is unchanged. At full, a same-cycle pop makes room, so the push succeeds and no overflow is flagged.

Decomposition:
- Package spi_acl_pkg holds:
  - opcodes OP_WRITE=0x0A, OP_READ=0x0B, OP_FIFO=0x0D;
  - addresses ADDR_DEVID, ADDR_X, ADDR_Y, ADDR_Z, ADDR_SCRATCH;
  - the state encoding.
- The package is shared with spi_controller.
- One sub-module, acl_sample_fifo: synchronous FIFO with push, pop, count, full and empty, parameterised by FIFO_DEPTH.

Test Plan:
- Reset, then read 0x00 (CS low; 0x0B, 0x00, 1 dummy byte) -> MISO returns 0xAD. MISO_OE is high only during the data byte.
- Set X, Y, Z = 0x11, 0x22, 0x33; issue 0x0B, 0x08 with a 3-byte burst; change X_DATA to 0x99 mid-burst -> returns 0x11, 0x22, 0x33. The snapshot holds.
- Issue 0x0A, 0x20 with data 0x5A, 0xC3; CS high; then 0x0B, 0x20 with a 2-byte read -> returns 0x5A, 0xC3.
- Push 0x01..0x03; issue 0x0D with a 4-byte read -> returns 0x01, 0x02, 0x03, 0x00. FIFO_COUNT ends at 0 and FIFO_OVERFLOW stays 0.
- Push FIFO_DEPTH+1 bytes -> FIFO_COUNT=16, FIFO_OVERFLOW=1, and the last byte is absent on readout.
- Abort and illegal-opcode cases:
  - 0x0A, 0x21, then 4 bits, then CS high -> scratch[0x21] stays 0x00.
  - Opcode 0x55 -> MISO stays 0, and the next transaction works normally.
